// File: rtl/ws2812_pixel_source.sv
// Frame-paced pixel source for a WS2812 chain: holds an LED colour store and
// streams brightness-scaled GRB pixels to a downstream serializer each frame period.
module ws2812_pixel_source #(
    parameter int LED_NUM   = 8,
    parameter int CLK_FRE   = 27_000_000,
    parameter int FRAME_DIV = CLK_FRE / 100,
    localparam int AW       = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic [7:0]    brightness,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [23:0]   pix_data,
    output logic          pix_last,
    output logic          frame_busy,
    output logic          frame_done
);

    localparam int TW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(LED_NUM - 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic            tick;
    logic [AW-1:0]   index;
    logic [23:0]     pix_data_r;
    logic            pix_last_r;
    logic            frame_done_r;
    logic            accept;
    logic            wr_ok;
    logic [23:0]     stored_pixel;

    logic [23:0] mem [LED_NUM] = '{default: 24'd0};

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return 8'(p >> 8);
    endfunction

    // Store is not reset; a read in the write cycle returns the old word.
    assign wr_ok = (32'(wr_addr) < 32'(LED_NUM));

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign stored_pixel = mem[index];

    assign tick = (timer == TIMER_MAX);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign accept = (state == SEND) && pix_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ticks outside IDLE fall through here unused, so they are never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (tick && enable) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: if (pix_ready) state_next = (index == LAST_IDX) ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index        <= '0;
            pix_data_r   <= '0;
            pix_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept && (index == LAST_IDX);
            if (state == IDLE && state_next == LOAD) begin
                index <= '0;
            end else if (accept && index != LAST_IDX) begin
                index <= index + 1'b1;
            end
            if (state == LOAD) begin
                pix_data_r <= {scale(stored_pixel[23:16], brightness),
                               scale(stored_pixel[15:8],  brightness),
                               scale(stored_pixel[7:0],   brightness)};
                pix_last_r <= (index == LAST_IDX);
            end
        end
    end

    assign pix_valid  = (state == SEND);
    assign pix_data   = pix_data_r;
    assign pix_last   = pix_last_r;
    assign frame_busy = (state != IDLE);
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_pixel_source.sv
// Directed + randomized bench for ws2812_pixel_source with a frame-level
// reference model (colour store, brightness arithmetic, tick schedule).
module tb_ws2812_pixel_source;

    localparam int LED_NUM   = 4;
    localparam int FRAME_DIV = 16;
    localparam int AW        = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic [7:0]    brightness = 8'hFF;
    logic          pix_ready = 1'b1;
    logic          pix_valid;
    logic [23:0]   pix_data;
    logic          pix_last;
    logic          frame_busy;
    logic          frame_done;

    ws2812_pixel_source #(
        .LED_NUM   (LED_NUM),
        .CLK_FRE   (1600),
        .FRAME_DIV (FRAME_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    // clock / reset-aware tick schedule
    always #5 clk = ~clk;

    int   t_model = 0;
    logic tick_model;
    always @(posedge clk) begin
        if (reset) t_model <= 0;
        else       t_model <= (t_model + 1) % FRAME_DIV;
    end
    assign tick_model = (t_model == FRAME_DIV - 1);

    // scoreboard state
    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] exp_q[$];
    logic [23:0] model_mem[LED_NUM] = '{default: 24'd0};
    int          exp_starts = 0;
    int          exp_dones = 0;
    logic [23:0] first_pix;

    // frame start / done monitor
    int   starts = 0;
    int   dones = 0;
    int   bad_starts = 0;
    logic busy_q = 1'b0;
    logic tick_q = 1'b0;
    always @(negedge clk) begin
        if (frame_busy && !busy_q) begin
            starts++;
            if (!tick_q) bad_starts++;
        end
        if (frame_done) dones++;
        busy_q <= frame_busy;
        tick_q <= tick_model;
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [23:0] px_ref(input logic [23:0] p, input int b);
        int g, r, bl;
        g  = (int'(p[23:16]) * (b + 1)) / 256;
        r  = (int'(p[15:8])  * (b + 1)) / 256;
        bl = (int'(p[7:0])   * (b + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    // driver tasks
    task automatic write_px(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 4 * FRAME_DIV; k++) begin
            if (tick_model) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input int stall_idx, input int stall_len, input bit keep_en,
                             input int wr_idx, input logic [23:0] wr_val,
                             input bit rand_br, input int base_br, input int abort_after);
        int          br[LED_NUM];
        logic [23:0] held_data;
        logic        held_last;
        logic [23:0] exp;
        bit          ok;
        for (int i = 0; i < LED_NUM; i++) begin
            br[i] = rand_br ? int'($urandom_range(0, 255)) : base_br;
            exp_q.push_back(px_ref(model_mem[i], br[i]));
        end
        enable    = 1'b1;
        pix_ready = 1'b1;
        wait_tick(ok);
        chk("tick_seen", 24'(ok), 24'd1);
        chk("idle_at_tick", 24'(frame_busy), 24'd0);
        exp_starts++;
        @(negedge clk);
        chk("load_busy", 24'(frame_busy), 24'd1);
        chk("load_no_valid", 24'(pix_valid), 24'd0);
        for (int i = 0; i < LED_NUM; i++) begin
            brightness = 8'(br[i]);
            if (!keep_en) enable = 1'b0;
            if (i == wr_idx) begin
                wr_en   = 1'b1;
                wr_addr = AW'(i);
                wr_data = wr_val;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (i == wr_idx) model_mem[i] = wr_val;
            brightness = 8'($urandom_range(0, 255));
            exp = exp_q.pop_front();
            chk("send_valid", 24'(pix_valid), 24'd1);
            chk("pix_data", pix_data, exp);
            chk("pix_last", 24'(pix_last), 24'(i == LED_NUM - 1));
            if (i == 0) first_pix = pix_data;
            if (i == stall_idx) begin
                pix_ready = 1'b0;
                held_data = pix_data;
                held_last = pix_last;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_valid", 24'(pix_valid), 24'd1);
                    chk("stall_data", pix_data, held_data);
                    chk("stall_last", 24'(pix_last), 24'(held_last));
                end
                pix_ready = 1'b1;
            end
            @(negedge clk);
            if (i < LED_NUM - 1) begin
                chk("reload_no_valid", 24'(pix_valid), 24'd0);
                chk("reload_busy", 24'(frame_busy), 24'd1);
            end else begin
                chk("done_pulse", 24'(frame_done), 24'd1);
                chk("done_idle", 24'(frame_busy), 24'd0);
                chk("done_no_valid", 24'(pix_valid), 24'd0);
                exp_dones++;
            end
            if (i == abort_after) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_valid", 24'(pix_valid), 24'd0);
                chk("abort_busy", 24'(frame_busy), 24'd0);
                chk("abort_last", 24'(pix_last), 24'd0);
                chk("abort_data", pix_data, 24'd0);
                chk("abort_done", 24'(frame_done), 24'd0);
                reset = 1'b0;
                exp_q.delete();
                break;
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 24'(pix_valid), 24'd0);
        chk("rst_busy", 24'(frame_busy), 24'd0);
        chk("rst_last", 24'(pix_last), 24'd0);
        chk("rst_data", pix_data, 24'd0);
        chk("rst_done", 24'(frame_done), 24'd0);
        reset = 1'b0;

        write_px(0, 24'h0000FF);
        write_px(1, 24'h00FF00);
        write_px(2, 24'hFF0000);
        write_px(3, 24'h123456);
        repeat (2 * FRAME_DIV) @(negedge clk);
        chk("disabled_no_start", 24'(starts), 24'd0);

        // full-brightness frame
        run_frame(-1, 0, 1'b1, -1, 24'h0, 1'b0, 255, -1);

        // brightness 127 arithmetic
        write_px(0, 24'hFF8001);
        run_frame(-1, 0, 1'b1, -1, 24'h0, 1'b0, 127, -1);
        chk("bright127", first_pix, 24'h7F4000);

        // short backpressure, enable dropped mid-frame
        run_frame(1, 5, 1'b0, -1, 24'h0, 1'b1, 0, -1);

        // long backpressure spanning several ticks
        run_frame(2, 40, 1'b1, -1, 24'h0, 1'b1, 0, -1);

        // reset after pixel 1, then clean restart
        run_frame(-1, 0, 1'b1, -1, 24'h0, 1'b1, 0, 1);
        run_frame(-1, 0, 1'b1, -1, 24'h0, 1'b1, 0, -1);

        // write collides with LOAD of index 2
        run_frame(-1, 0, 1'b1, 2, 24'hABCDEF, 1'b0, 255, -1);
        run_frame(-1, 0, 1'b1, -1, 24'h0, 1'b0, 255, -1);

        // randomized store, brightness and backpressure
        repeat (4) begin
            for (int a = 0; a < LED_NUM; a++) write_px(a, 24'($urandom));
            run_frame(int'($urandom_range(0, LED_NUM - 1)), int'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)), -1, 24'h0, 1'b1, 0, -1);
        end

        repeat (2) @(negedge clk);
        chk("start_count", 24'(starts), 24'(exp_starts));
        chk("done_count", 24'(dones), 24'(exp_dones));
        chk("starts_on_tick", 24'(bad_starts), 24'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
